// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for the VGA display path. Two 11-bit counters
// (h_cnt, v_cnt) walk the frame in the order ACTIVE, FP, SYNC, BP, both
// horizontally (in clocks) and vertically (in lines). A phase register is
// kept next to each counter. All outputs are registered and are decoded from
// the next-count values, so each output lines up with the counter value it
// is registered alongside.
//
// Optional feature macro: VGA_TIMING_SYNC_DLY_EN
//   When defined, VGA_HS, VGA_VS, FRAME_START and LINE_END each pass through
//   one more register, so they lag VGA_IF_RGBEN and CURRENT_X/Y by one clock.
//   When undefined, all outputs are coincident.
//
// Ports:
//   VGA_CLK      in   pixel clock
//   RST_N        in   asynchronous reset, active-low
//   TIMING_EN    in   run enable; low holds the generator at the frame origin
//   VGA_HS       out  horizontal sync (asserted level HS_POL)
//   VGA_VS       out  vertical sync (asserted level VS_POL)
//   VGA_IF_RGBEN out  high only in the visible region
//   CURRENT_X    out  horizontal count h_cnt
//   CURRENT_Y    out  vertical count v_cnt
//   DISPLAY_X    out  constant H_ACTIVE
//   DISPLAY_Y    out  constant V_ACTIVE
//   FRAME_START  out  one-clock pulse at h_cnt=0, v_cnt=0
//   LINE_END     out  one-clock pulse at h_cnt=H_TOTAL-1
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        VGA_CLK,
  input  logic        RST_N,
  input  logic        TIMING_EN,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_IF_RGBEN,
  output logic [10:0] CURRENT_X,
  output logic [10:0] CURRENT_Y,
  output logic [10:0] DISPLAY_X,
  output logic [10:0] DISPLAY_Y,
  output logic        FRAME_START,
  output logic        LINE_END
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Phase boundaries. With a zero-length back porch the BP start equals the
  // total, which the next count never reaches, so BP is skipped.
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_START   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_START   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_FP_START   = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_BP_START   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  // Phase of the next count. SYNC is tested before FP so that a zero-length
  // front porch (FP start == SYNC start) goes straight to SYNC.
  function automatic phase_t next_phase(
    input logic [10:0] cnt,
    input phase_t      cur,
    input logic [10:0] fp_start,
    input logic [10:0] sync_start,
    input logic [10:0] bp_start
  );
    phase_t nxt;
    if (cnt == 11'd0) begin
      nxt = PH_ACTIVE;
    end else if (cnt == bp_start) begin
      nxt = PH_BP;
    end else if (cnt == sync_start) begin
      nxt = PH_SYNC;
    end else if (cnt == fp_start) begin
      nxt = PH_FP;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  // running_r is low in reset and while disabled. The first enabled clock
  // therefore loads the origin (0,0) and does not advance, which makes
  // FRAME_START and RGBEN appear on that first clock.
  logic        running_r;
  logic [10:0] h_cnt_r;
  logic [10:0] v_cnt_r;
  phase_t      h_phase_r;
  phase_t      v_phase_r;
  logic        hs_r;
  logic        vs_r;
  logic        rgben_r;
  logic        fs_r;
  logic        le_r;

  logic [10:0] h_next_s;
  logic [10:0] v_next_s;
  phase_t      h_phase_next_s;
  phase_t      v_phase_next_s;

  // Next-count and next-phase decode.
  always_comb begin
    h_next_s       = 11'd0;
    v_next_s       = 11'd0;
    h_phase_next_s = PH_ACTIVE;
    v_phase_next_s = PH_ACTIVE;
    if (!running_r) begin
      h_next_s = 11'd0;
      v_next_s = 11'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_next_s = 11'd0;
      if (v_cnt_r == V_LAST) begin
        v_next_s = 11'd0;
      end else begin
        v_next_s = v_cnt_r + 11'd1;
      end
    end else begin
      h_next_s = h_cnt_r + 11'd1;
      v_next_s = v_cnt_r;
    end
    h_phase_next_s = next_phase(h_next_s, h_phase_r, H_FP_START, H_SYNC_START, H_BP_START);
    v_phase_next_s = next_phase(v_next_s, v_phase_r, V_FP_START, V_SYNC_START, V_BP_START);
  end

  // Counters, phase registers and outputs decoded from the next state.
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      running_r <= 1'b0;
      h_cnt_r   <= 11'd0;
      v_cnt_r   <= 11'd0;
      h_phase_r <= PH_ACTIVE;
      v_phase_r <= PH_ACTIVE;
      hs_r      <= ~HS_POL;
      vs_r      <= ~VS_POL;
      rgben_r   <= 1'b0;
      fs_r      <= 1'b0;
      le_r      <= 1'b0;
    end else if (!TIMING_EN) begin
      running_r <= 1'b0;
      h_cnt_r   <= 11'd0;
      v_cnt_r   <= 11'd0;
      h_phase_r <= PH_ACTIVE;
      v_phase_r <= PH_ACTIVE;
      hs_r      <= ~HS_POL;
      vs_r      <= ~VS_POL;
      rgben_r   <= 1'b0;
      fs_r      <= 1'b0;
      le_r      <= 1'b0;
    end else begin
      running_r <= 1'b1;
      h_cnt_r   <= h_next_s;
      v_cnt_r   <= v_next_s;
      h_phase_r <= h_phase_next_s;
      v_phase_r <= v_phase_next_s;
      hs_r      <= (h_phase_next_s == PH_SYNC) ? HS_POL : ~HS_POL;
      vs_r      <= (v_phase_next_s == PH_SYNC) ? VS_POL : ~VS_POL;
      rgben_r   <= (h_phase_next_s == PH_ACTIVE) && (v_phase_next_s == PH_ACTIVE);
      fs_r      <= (h_next_s == 11'd0) && (v_next_s == 11'd0);
      le_r      <= (h_next_s == H_LAST);
    end
  end

`ifdef VGA_TIMING_SYNC_DLY_EN
  logic hs_dly_r;
  logic vs_dly_r;
  logic fs_dly_r;
  logic le_dly_r;

  // One-clock delay of syncs and pulses to match a registered RGB stage.
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      hs_dly_r <= ~HS_POL;
      vs_dly_r <= ~VS_POL;
      fs_dly_r <= 1'b0;
      le_dly_r <= 1'b0;
    end else begin
      hs_dly_r <= hs_r;
      vs_dly_r <= vs_r;
      fs_dly_r <= fs_r;
      le_dly_r <= le_r;
    end
  end

  assign VGA_HS      = hs_dly_r;
  assign VGA_VS      = vs_dly_r;
  assign FRAME_START = fs_dly_r;
  assign LINE_END    = le_dly_r;
`else
  assign VGA_HS      = hs_r;
  assign VGA_VS      = vs_r;
  assign FRAME_START = fs_r;
  assign LINE_END    = le_r;
`endif

  assign VGA_IF_RGBEN = rgben_r;
  assign CURRENT_X    = h_cnt_r;
  assign CURRENT_Y    = v_cnt_r;
  assign DISPLAY_X    = 11'(H_ACTIVE);
  assign DISPLAY_Y    = 11'(V_ACTIVE);

endmodule
